// File: rtl/mem_bus_arbiter.sv
// Two-requester memory bus arbiter: round-robin FSM with hold-time preemption,
// shared bus mux from the current owner, and address decode of slave read data.
module mem_bus_arbiter #(
  parameter int unsigned MAX_HOLD = 32
) (
  input  logic         Clk,
  input  logic         nReset,
  input  logic         req0,
  input  logic         req1,
  input  logic [15:0]  addr0,
  input  logic [15:0]  addr1,
  input  logic         nRead0,
  input  logic         nRead1,
  input  logic         nWrite0,
  input  logic         nWrite1,
  input  logic [255:0] wdata0,
  input  logic [255:0] wdata1,
  input  logic [255:0] InstructDataOut,
  input  logic [255:0] MemDataOut,
  input  logic [255:0] MatrixDataOut,
  output logic         gnt0,
  output logic         gnt1,
  output logic [15:0]  address,
  output logic         nRead,
  output logic         nWrite,
  output logic [255:0] busDataOut,
  output logic [255:0] rdata,
  output logic         timeout,
  output logic         decodeErr
);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2, TURN = 2'd3} state_t;

  state_t       state_q, state_d;
  logic         rr_q, rr_d;
  logic [7:0]   cnt_q, cnt_d;
  logic         gnt0_q, gnt1_q, timeout_q, timeout_d;
  logic         hold_done;
  logic [7:0]   cnt_inc;
  logic         mapped;

  // Counter holds completed grant cycles, so this edge ends grant cycle cnt_q+1.
  assign hold_done = (32'(cnt_q) + 32'd1) >= MAX_HOLD;
  assign cnt_inc   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    cnt_d     = 8'd0;
    timeout_d = 1'b0;
    case (state_q)
      IDLE, TURN: begin
        if (req0 && req1)  state_d = rr_q ? OWN1 : OWN0;
        else if (req0)     state_d = OWN0;
        else if (req1)     state_d = OWN1;
        else               state_d = IDLE;
      end
      OWN0: begin
        if (!req0) begin
          state_d = TURN;
          rr_d    = 1'b1;
        end else if (req1 && hold_done) begin
          state_d   = TURN;
          rr_d      = 1'b1;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      OWN1: begin
        if (!req1) begin
          state_d = TURN;
          rr_d    = 1'b0;
        end else if (req0 && hold_done) begin
          state_d   = TURN;
          rr_d      = 1'b0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q   <= IDLE;
      rr_q      <= 1'b0;
      cnt_q     <= 8'd0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      cnt_q     <= cnt_d;
      gnt0_q    <= (state_d == OWN0);
      gnt1_q    <= (state_d == OWN1);
      timeout_q <= timeout_d;
    end
  end

  assign gnt0    = gnt0_q;
  assign gnt1    = gnt1_q;
  assign timeout = timeout_q;

  // Strobes pass through untouched, even both-low; arbitration is per owner only.
  always_comb begin
    address    = 16'h0000;
    nRead      = 1'b1;
    nWrite     = 1'b1;
    busDataOut = '0;
    case (state_q)
      OWN0: begin
        address    = addr0;
        nRead      = nRead0;
        nWrite     = nWrite0;
        busDataOut = wdata0;
      end
      OWN1: begin
        address    = addr1;
        nRead      = nRead1;
        nWrite     = nWrite1;
        busDataOut = wdata1;
      end
      default: ;
    endcase
  end

  always_comb begin
    rdata  = '0;
    mapped = 1'b1;
    if (address[15])                   rdata = InstructDataOut;
    else if (address[15:12] == 4'h2)   rdata = MatrixDataOut;
    else if (address[15:12] == 4'h0)   rdata = MemDataOut;
    else                               mapped = 1'b0;
  end

  assign decodeErr = !mapped && (!nRead || !nWrite);

endmodule
